// File: rtl/sequence_generator.sv
// Serial pattern source: divides mclk into the bit clock clk and shifts a
// latched pattern out on x MSB first, changing x only on clk falling edges.
module sequence_generator #(
    parameter int   WIDTH    = 16,
    parameter int   DIV      = 1,
    parameter logic IDLE_LVL = 1'b0,
    localparam int  LW       = $clog2(WIDTH + 1)
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    output logic             clk,
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_ARM  = 2'b01;
    localparam logic [1:0] S_SEND = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             clk_q;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [LW-1:0]    rem_q, rem_d;
    logic             x_q, x_d;
    logic             done_q, done_d;

    logic             wrap, fall_tick;
    logic [LW-1:0]    len_eff;

    assign wrap      = (cnt_q == CNT_MAX);
    assign cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    assign fall_tick = wrap & clk_q;
    assign len_eff   = (len > WIDTH_L) ? WIDTH_L : len;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        x_d     = x_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                x_d = IDLE_LVL;
                if (start && (len_eff != '0)) begin
                    // Left-align so the first bit to send sits at the MSB.
                    sh_d    = pattern << (WIDTH_L - len_eff);
                    rem_d   = len_eff;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (fall_tick) begin
                    x_d     = sh_q[WIDTH-1];
                    sh_d    = sh_q << 1;
                    rem_d   = rem_q - 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (fall_tick) begin
                    if (rem_q != '0) begin
                        x_d   = sh_q[WIDTH-1];
                        sh_d  = sh_q << 1;
                        rem_d = rem_q - 1'b1;
                    end else begin
                        x_d     = IDLE_LVL;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                // DONE: hold idle level one more clk period before release.
                if (fall_tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            state_q <= S_IDLE;
            sh_q    <= '0;
            rem_q   <= '0;
            x_q     <= IDLE_LVL;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clk_q   <= wrap ? ~clk_q : clk_q;
            state_q <= state_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            x_q     <= x_d;
            done_q  <= done_d;
        end
    end

    assign clk   = clk_q;
    assign x     = x_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: one DIV=1 and one DIV=2 instance.
module tb_sequence_generator;

    logic        mclk = 1'b0;
    logic        reset;
    logic        start1, start2;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic        clk1, x1, busy1, done1;
    logic [1:0]  state1;
    logic        clk2, x2, busy2, done2;
    logic [1:0]  state2;

    int errors = 0;
    int checks = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    bit sel = 1'b0;

    logic       clk_s, x_s, busy_s, done_s;
    logic [1:0] state_s;
    int         done_cnt_s;

    assign clk_s      = sel ? clk2 : clk1;
    assign x_s        = sel ? x2 : x1;
    assign busy_s     = sel ? busy2 : busy1;
    assign done_s     = sel ? done2 : done1;
    assign state_s    = sel ? state2 : state1;
    assign done_cnt_s = sel ? done_cnt2 : done_cnt1;

    sequence_generator #(.WIDTH(16), .DIV(1), .IDLE_LVL(1'b0)) dut1 (
        .mclk(mclk), .reset(reset), .start(start1), .pattern(pattern), .len(len),
        .clk(clk1), .x(x1), .busy(busy1), .done(done1), .state(state1)
    );

    sequence_generator #(.WIDTH(16), .DIV(2), .IDLE_LVL(1'b0)) dut2 (
        .mclk(mclk), .reset(reset), .start(start2), .pattern(pattern), .len(len),
        .clk(clk2), .x(x2), .busy(busy2), .done(done2), .state(state2)
    );

    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (done1 === 1'b1) done_cnt1++;
        if (done2 === 1'b1) done_cnt2++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start2 = v; else start1 = v;
    endtask

    task automatic wait_rise(output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = clk_s;
        for (int i = 0; i < 20; i++) begin
            @(posedge mclk); #1;
            if (clk_s === 1'b1 && prev === 1'b0) begin
                ok = 1'b1;
                break;
            end
            prev = clk_s;
        end
    endtask

    task automatic wait_state(input logic [1:0] st, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge mclk); #1;
            if (state_s === st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Start a transfer and check every bit at the clk rising edge.
    task automatic run_send(input bit s, input logic [15:0] pat, input logic [4:0] ln,
                            input int nb, input logic [15:0] ex, input bit disturb,
                            input bit mid);
        bit ok, seen, busy_bad;
        int d0;
        sel = s;
        pattern = pat;
        len = ln;
        set_start(1'b1);
        @(posedge mclk); #1;
        set_start(1'b0);
        chk("busy_after_start", busy_s, 1'b1);
        chk("state_arm", state_s, 2'b01);
        wait_state(2'b10, ok);
        chk("reach_send", ok, 1'b1);
        d0 = done_cnt_s;
        if (disturb) begin
            set_start(1'b1);
            pattern = 16'hFFFF;
            len = 5'd4;
        end
        for (int i = 0; i < nb; i++) begin
            wait_rise(ok);
            chk("clk_rise", ok, 1'b1);
            chk("bit", x_s, ex[nb-1-i]);
            if (mid) begin
                @(posedge mclk); #1;
                chk("bit_hold", x_s, ex[nb-1-i]);
            end
        end
        if (disturb) set_start(1'b0);
        wait_rise(ok);
        chk("idle_after", x_s, 1'b0);
        seen = 1'b0;
        busy_bad = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge mclk); #1;
            if (done_s === 1'b1) begin
                seen = 1'b1;
                chk("done_state", state_s, 2'b00);
                chk("done_busy", busy_s, 1'b0);
            end else if (busy_s !== 1'b1) begin
                busy_bad = 1'b1;
            end
        end
        chk("done_seen", seen, 1'b1);
        chk("busy_held", busy_bad, 1'b0);
        @(posedge mclk); #1;
        chk("done_one_cycle", done_s, 1'b0);
        chk("done_count", 16'(done_cnt_s - d0), 16'd1);
    endtask

    initial begin
        bit ok;
        int d0;
        logic [9:0] b2b;

        // Reset held for 13 ns.
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; pattern = '0; len = '0;
        #6;
        chk("rst_clk", clk1, 1'b0);
        chk("rst_x", x1, 1'b0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_state", state1, 2'b00);
        #6;
        chk("rst_clk2", clk2, 1'b0);
        chk("rst_state2", state2, 2'b00);
        #1 reset = 1'b0;
        @(posedge mclk); #1;
        chk("div1_clk_hi", clk1, 1'b1);
        chk("div2_clk_lo", clk2, 1'b0);
        @(posedge mclk); #1;
        chk("div1_clk_lo", clk1, 1'b0);
        chk("div2_clk_hi", clk2, 1'b1);

        // Basic 4-bit send, DIV=1.
        run_send(1'b0, 16'h000B, 5'd4, 4, 16'h000B, 1'b0, 1'b0);

        // Full width with len saturating, DIV=2.
        run_send(1'b1, 16'hA5C3, 5'd20, 16, 16'hA5C3, 1'b0, 1'b1);

        // len=0 request is ignored.
        sel = 1'b0;
        d0 = done_cnt1;
        pattern = 16'h00FF; len = 5'd0; start1 = 1'b1;
        repeat (6) begin @(posedge mclk); #1; end
        chk("len0_state", state1, 2'b00);
        chk("len0_busy", busy1, 1'b0);
        start1 = 1'b0;
        repeat (4) begin @(posedge mclk); #1; end
        chk("len0_no_done", 16'(done_cnt1 - d0), 16'd0);

        // Start re-asserted during SEND does not disturb the stream.
        run_send(1'b0, 16'h0009, 5'd4, 4, 16'h0009, 1'b1, 1'b0);

        // Asynchronous reset after the 2nd bit.
        sel = 1'b0;
        pattern = 16'h000A; len = 5'd4; start1 = 1'b1;
        @(posedge mclk); #1;
        start1 = 1'b0;
        wait_state(2'b10, ok);
        chk("rst_mid_send", ok, 1'b1);
        wait_rise(ok);
        chk("rst_mid_b0", x1, 1'b1);
        wait_rise(ok);
        chk("rst_mid_b1", x1, 1'b0);
        d0 = done_cnt1;
        #3 reset = 1'b1;
        #1;
        chk("async_x", x1, 1'b0);
        chk("async_state", state1, 2'b00);
        chk("async_busy", busy1, 1'b0);
        chk("async_clk", clk1, 1'b0);
        @(posedge mclk); #1;
        reset = 1'b0;
        repeat (10) begin @(posedge mclk); #1; end
        chk("rst_no_done", 16'(done_cnt1 - d0), 16'd0);
        chk("rst_stay_idle", state1, 2'b00);
        run_send(1'b0, 16'h0006, 5'd3, 3, 16'h0006, 1'b0, 1'b0);

        // Back-to-back with start held high: 110 then two idle periods.
        sel = 1'b0;
        pattern = 16'h0006; len = 5'd3; start1 = 1'b1;
        wait_state(2'b10, ok);
        chk("b2b_send", ok, 1'b1);
        d0 = done_cnt1;
        b2b = 10'b1100011000;
        for (int i = 0; i < 10; i++) begin
            wait_rise(ok);
            chk("b2b_rise", ok, 1'b1);
            chk("b2b_bit", x1, b2b[9-i]);
        end
        chk("b2b_done_count", 16'(done_cnt1 - d0), 16'd2);
        start1 = 1'b0;
        wait_state(2'b00, ok);
        chk("b2b_idle", ok, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
